fetch_unit: RTL and testbench

// Instruction-fetch stage feeding decode and the register-file hazard check.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request port, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pause,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic        stall;
  logic        ld_fetch, ld_hold, bubble, hold_we, flush;
  logic [31:0] pc_plus4;

  assign stall     = |pause;
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    ld_fetch = 1'b0;
    ld_hold  = 1'b0;
    bubble   = 1'b0;
    hold_we  = 1'b0;
    flush    = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !stall) begin
          ld_fetch = 1'b1;
        end else if (imem_ready) begin
          hold_we = 1'b1;
          state_n = S_HOLD;
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          ld_hold = 1'b1;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A taken branch/jump overrides everything, including a same-cycle response.
    if (redirect_valid) begin
      flush    = 1'b1;
      ld_fetch = 1'b0;
      ld_hold  = 1'b0;
      bubble   = 1'b0;
      hold_we  = 1'b0;
      state_n  = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      hold_buf    <= 32'h0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h0;
    end else begin
      if (hold_we) begin
        hold_buf <= imem_rdata;
      end
      if (flush) begin
        pc          <= redirect_pc & ~32'h3;
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
        if_id_pc    <= 32'h0;
        if_id_pc4   <= 32'h0;
      end else if (ld_fetch || ld_hold) begin
        pc          <= pc_plus4;
        if_id_valid <= 1'b1;
        if_id_instr <= ld_hold ? hold_buf : imem_rdata;
        if_id_pc    <= pc;
        if_id_pc4   <= pc_plus4;
      end else if (bubble) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if ((ld_fetch || ld_hold) && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (stall && !redirect_valid && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed + randomized bench for fetch_unit against a queue-based model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] XORPAT    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pause;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the fetcher either waits one cycle after reset, owns a parked
  // instruction (held queue), or is actively fetching from m_pc.
  bit          m_init = 0;
  bit          m_started;
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  logic        m_v;
  logic [31:0] m_i, m_p, m_p4;
  logic [31:0] m_fetched, m_stall;

  task automatic deliver(input logic [31:0] instr);
    m_v  = 1'b1;
    m_i  = instr;
    m_p  = m_pc;
    m_p4 = m_pc + 32'd4;
    m_pc = m_pc + 32'd4;
    m_fetched = m_fetched + 32'd1;
  endtask

  always @(posedge clk) begin
    logic st;
    st = |pause;
    m_init = 1;
    if (!rst) begin
      m_started = 0; m_pc = RESET_PC; m_held.delete();
      m_v = 0; m_i = NOP_INSTR; m_p = 0; m_p4 = 0;
      m_fetched = 0; m_stall = 0;
    end else begin
      if (st && !redirect_valid) m_stall = m_stall + 32'd1;
      if (redirect_valid) begin
        m_started = 1; m_held.delete();
        m_pc = redirect_pc & ~32'h3;
        m_v = 0; m_i = NOP_INSTR; m_p = 0; m_p4 = 0;
      end else if (!m_started) begin
        m_started = 1;
      end else if (m_held.size() != 0) begin
        if (!st) deliver(m_held.pop_front());
      end else if (imem_ready) begin
        if (st) m_held.push_back(imem_rdata);
        else deliver(imem_rdata);
      end else if (!st) begin
        m_v = 0; m_i = NOP_INSTR;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic exp_req;
      exp_req = m_started && (m_held.size() == 0);
      chk("m_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("m_addr", imem_addr, m_pc);
      chk("m_valid", {31'b0, if_id_valid}, {31'b0, m_v});
      chk("m_instr", if_id_instr, m_i);
      chk("m_pc", if_id_pc, m_p);
      chk("m_pc4", if_id_pc4, m_p4);
`ifdef FETCH_PERF_CNT_EN
      chk("m_perf_fetched", perf_fetched, m_fetched);
      chk("m_perf_stall", perf_stall, m_stall);
`endif
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ XORPAT;
  endfunction

  initial begin
    rst = 1'b0; pause = 2'b00; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    tick; tick;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, NOP_INSTR);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);

    rst = 1'b1;
    tick;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    chk("first_valid", {31'b0, if_id_valid}, 32'd0);

    imem_ready = 1'b1;
    imem_rdata = mem(imem_addr);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stream_pc", if_id_pc, 32'(4 * k));
      chk("stream_instr", if_id_instr, 32'(4 * k) ^ XORPAT);
      imem_rdata = mem(imem_addr);
    end

    pause = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stall_pc", if_id_pc, 32'd8);
      chk("stall_valid", {31'b0, if_id_valid}, 32'd1);
    end
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    pause = 2'b00;
    tick;
    chk("release_pc", if_id_pc, 32'd12);
    chk("release_instr", if_id_instr, 32'h0000_000C ^ XORPAT);
    chk("release_addr", imem_addr, 32'd16);

    imem_rdata = mem(imem_addr);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick;
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_valid", {31'b0, if_id_valid}, 32'd0);
    redirect_valid = 1'b0;
    imem_rdata = mem(imem_addr);
    tick;
    chk("redir_pc", if_id_pc, 32'h0000_0100);
    chk("redir_instr", if_id_instr, 32'h0000_0100 ^ XORPAT);

    imem_rdata = mem(imem_addr);
    pause = 2'b11;
    tick;
    chk("prio_hold_req", {31'b0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick;
    chk("prio_addr", imem_addr, 32'h0000_0200);
    chk("prio_req", {31'b0, imem_req}, 32'd1);
    chk("prio_valid", {31'b0, if_id_valid}, 32'd0);
    redirect_valid = 1'b0; pause = 2'b00;
    imem_rdata = mem(imem_addr);
    tick;
    chk("prio_pc", if_id_pc, 32'h0000_0200);
    chk("prio_instr", if_id_instr, 32'h0000_0200 ^ XORPAT);

    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0; imem_ready = 1'b0;
    tick;
    chk("slow_bubble1", {31'b0, if_id_valid}, 32'd0);
    tick;
    chk("slow_bubble2", {31'b0, if_id_valid}, 32'd0);
    chk("slow_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1; imem_rdata = mem(imem_addr);
    tick;
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_valid", {31'b0, if_id_valid}, 32'd1);

    for (int n = 0; n < 4000; n++) begin
      rst            = ($urandom_range(0, 299) != 0);
      pause          = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      imem_ready     = ($urandom_range(0, 9) < 7);
      imem_rdata     = $urandom;
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
